// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and default sizes for the load-use / miss
//               hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int c_REG_W_DEFAULT        = 5;
    localparam int c_MISS_TIMEOUT_DEFAULT = 64;
    localparam int c_CNT_W_DEFAULT        = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } miss_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_miss_fsm.sv
`default_nettype none
// ============================================================================
// Module      : hazard_miss_fsm
// Description : D-cache miss tracker: stall_mem generation, miss timeout
//               watchdog and saturating miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_miss_fsm
    import hazard_pkg::*;
#(
    parameter int MISS_TIMEOUT = c_MISS_TIMEOUT_DEFAULT,
    parameter int CNT_W        = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_mem_load_valid,
    input  logic             i_cache_hit,
    input  logic             i_refill_done,
    output logic             o_stall_mem,
    output logic [CNT_W-1:0] o_miss_count,
    output logic             o_timeout_err
);

    localparam int               c_TW           = $clog2(MISS_TIMEOUT + 1);
    localparam logic [c_TW-1:0]  c_TIMEOUT_LAST = c_TW'(MISS_TIMEOUT - 1);
    localparam logic [c_TW-1:0]  c_TMO_ONE      = c_TW'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;

    miss_state_t      r_state;
    miss_state_t      w_next;
    logic             w_miss_start;
    logic             w_stall_mem;
    logic [c_TW-1:0]  r_tmo_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_miss_count;

    always_comb begin
        w_next       = r_state;
        w_miss_start = 1'b0;
        w_stall_mem  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Stall in the same cycle the miss is seen, before the FSM moves.
                if (i_mem_load_valid && !i_cache_hit) begin
                    w_next       = ST_MISS;
                    w_miss_start = 1'b1;
                    w_stall_mem  = 1'b1;
                end
            end
            ST_MISS: begin
                w_stall_mem = 1'b1;
                if (i_refill_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss_start) begin
                r_tmo_cnt <= '0;
                if (r_miss_count != c_CNT_MAX) begin
                    r_miss_count <= r_miss_count + c_CNT_ONE;
                end
            end else if (r_state == ST_MISS) begin
                // Timeout only flags the condition; the refill still ends the miss.
                if (r_tmo_cnt == c_TIMEOUT_LAST) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
                end
            end
        end
    end

    assign o_stall_mem   = w_stall_mem;
    assign o_miss_count  = r_miss_count;
    assign o_timeout_err = r_timeout;

endmodule : hazard_miss_fsm
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Load-use busy-bit scoreboard and pipeline stall/flush control
//               for a classic 5-stage pipeline with a blocking D-cache.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W        = c_REG_W_DEFAULT,
    parameter int MISS_TIMEOUT = c_MISS_TIMEOUT_DEFAULT,
    parameter int CNT_W        = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_is_load,
    input  logic [REG_W-1:0] issue_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             mem_load_valid,
    input  logic             cache_hit,
    input  logic             refill_done,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             branch_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic [CNT_W-1:0] miss_count,
    output logic             timeout_err
);

    localparam int c_NREGS = 2 ** REG_W;

    logic [c_NREGS-1:0] r_busy;
    logic               w_hz_rs1;
    logic               w_hz_rs2;
    logic               w_load_use;
    logic               w_stall_mem;
    logic               w_flush_id;
    logic               w_stall_id;
    logic               w_busy_set;

    hazard_miss_fsm #(
        .MISS_TIMEOUT (MISS_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_miss_fsm (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_mem_load_valid (mem_load_valid),
        .i_cache_hit      (cache_hit),
        .i_refill_done    (refill_done),
        .o_stall_mem      (w_stall_mem),
        .o_miss_count     (miss_count),
        .o_timeout_err    (timeout_err)
    );

    // A result being written back this cycle is forwarded, so it is not a hazard.
    assign w_hz_rs1   = id_rs1_used && (id_rs1 != '0) && r_busy[id_rs1]
                        && !(wb_valid && (wb_rd == id_rs1));
    assign w_hz_rs2   = id_rs2_used && (id_rs2 != '0) && r_busy[id_rs2]
                        && !(wb_valid && (wb_rd == id_rs2));
    assign w_load_use = w_hz_rs1 || w_hz_rs2;

    assign w_flush_id = branch_taken && !w_stall_mem;
    assign w_stall_id = w_stall_mem || (w_load_use && !w_flush_id);
    assign w_busy_set = issue_valid && issue_is_load && (issue_rd != '0)
                        && !w_stall_id && !w_flush_id && !w_stall_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (wb_valid) begin
                r_busy[wb_rd] <= 1'b0;
            end
            // Later assignment wins: a set in the same cycle as a clear keeps the bit.
            if (w_busy_set) begin
                r_busy[issue_rd] <= 1'b1;
            end
        end
    end

    assign stall_mem = w_stall_mem;
    assign flush_id  = w_flush_id;
    assign stall_id  = w_stall_id;
    assign stall_if  = w_stall_id;
    assign bubble_ex = !w_stall_mem && (w_flush_id || w_load_use);

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_is_load;
    logic [4:0]  issue_rd, id_rs1, id_rs2, wb_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        mem_load_valid, cache_hit, refill_done, wb_valid, branch_taken;
    logic        stall_if, stall_id, bubble_ex, stall_mem, flush_id, timeout_err;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_is_load  (issue_is_load),
        .issue_rd       (issue_rd),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .mem_load_valid (mem_load_valid),
        .cache_hit      (cache_hit),
        .refill_done    (refill_done),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .branch_taken   (branch_taken),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .bubble_ex      (bubble_ex),
        .stall_mem      (stall_mem),
        .flush_id       (flush_id),
        .miss_count     (miss_count),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    task automatic clear_inputs();
        issue_valid = 0; issue_is_load = 0; issue_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        mem_load_valid = 0; cache_hit = 0; refill_done = 0;
        wb_valid = 0; wb_rd = 0; branch_taken = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        clear_inputs();
        issue_valid = 1; issue_is_load = 1; issue_rd = rd;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        n_checks++;
        if ({stall_if, stall_id, bubble_ex, stall_mem, flush_id, timeout_err} !== 6'b0 || miss_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: flags=%b miss_count=%0d expected flags=000000 miss_count=0",
                     {stall_if, stall_id, bubble_ex, stall_mem, flush_id, timeout_err}, miss_count);
        end
        #10;
        rst_n = 1;
        next_cycle();
        #2;
        n_checks++;
        if ({stall_id, stall_mem} !== 2'b00) begin
            n_errors++;
            $display("FAIL post_reset_idle: stall_id=%b stall_mem=%b expected 0 0", stall_id, stall_mem);
        end
    endtask

    task automatic test_load_use();
        issue_load(5'd5);
        id_rs1 = 5; id_rs1_used = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if ({stall_id, stall_if, bubble_ex, flush_id} !== 4'b1110) begin
                n_errors++;
                $display("FAIL lu_stall[%0d]: stall_id=%b stall_if=%b bubble_ex=%b flush_id=%b expected 1 1 1 0",
                         i, stall_id, stall_if, bubble_ex, flush_id);
            end
            next_cycle();
        end
        wb_valid = 1; wb_rd = 5;
        #2;
        n_checks++;
        if ({stall_id, bubble_ex} !== 2'b00) begin
            n_errors++;
            $display("FAIL lu_wb_same_cycle: stall_id=%b bubble_ex=%b expected 0 0", stall_id, bubble_ex);
        end
        next_cycle();
        wb_valid = 0;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_after_clear: stall_id=%b expected 0", stall_id);
        end
        issue_load(5'd3);
        id_rs2 = 3; id_rs2_used = 0;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_rs2_unused: stall_id=%b expected 0", stall_id);
        end
        id_rs2_used = 1;
        #1;
        n_checks++;
        if ({stall_id, bubble_ex} !== 2'b11) begin
            n_errors++;
            $display("FAIL lu_rs2_used: stall_id=%b bubble_ex=%b expected 1 1", stall_id, bubble_ex);
        end
        wb_valid = 1; wb_rd = 3;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_x0_and_nonload();
        issue_load(5'd0);
        id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
        #2;
        n_checks++;
        if ({stall_id, bubble_ex} !== 2'b00) begin
            n_errors++;
            $display("FAIL x0_no_stall: stall_id=%b bubble_ex=%b expected 0 0", stall_id, bubble_ex);
        end
        clear_inputs();
        issue_valid = 1; issue_is_load = 0; issue_rd = 11;
        next_cycle();
        clear_inputs();
        id_rs1 = 11; id_rs1_used = 1;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL nonload_no_busy: stall_id=%b expected 0", stall_id);
        end
        clear_inputs();
    endtask

    task automatic test_miss();
        int n_stall;
        mem_load_valid = 1; cache_hit = 1;
        #2;
        n_checks++;
        if (stall_mem !== 1'b0) begin
            n_errors++;
            $display("FAIL hit_no_stall: stall_mem=%b expected 0", stall_mem);
        end
        next_cycle();
        issue_load(5'd6);
        mem_load_valid = 1; cache_hit = 0;
        #2;
        n_checks++;
        if ({stall_mem, stall_id, stall_if, bubble_ex} !== 4'b1110) begin
            n_errors++;
            $display("FAIL miss_comb: stall_mem=%b stall_id=%b stall_if=%b bubble_ex=%b expected 1 1 1 0",
                     stall_mem, stall_id, stall_if, bubble_ex);
        end
        n_stall = (stall_mem === 1'b1) ? 1 : 0;
        next_cycle();
        mem_load_valid = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) begin wb_valid = 1; wb_rd = 6; end
            if (i == 3) begin wb_valid = 0; issue_valid = 1; issue_is_load = 1; issue_rd = 9; end
            if (i == 4) clear_inputs();
            if (i == 10) refill_done = 1;
            #2;
            if (stall_mem === 1'b1) n_stall++;
            next_cycle();
        end
        clear_inputs();
        #2;
        n_checks++;
        if (stall_mem !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_released: stall_mem=%b expected 0", stall_mem);
        end
        n_checks++;
        if (n_stall != 11) begin
            n_errors++;
            $display("FAIL miss_stall_cycles: got %0d expected 11", n_stall);
        end
        n_checks++;
        if (miss_count !== 16'd1) begin
            n_errors++;
            $display("FAIL miss_count_1: got %0d expected 1", miss_count);
        end
        id_rs1 = 6; id_rs1_used = 1; id_rs2 = 9; id_rs2_used = 1;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_busy_clear_set_block: stall_id=%b expected 0", stall_id);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        issue_load(5'd4);
        id_rs1 = 4; id_rs1_used = 1; branch_taken = 1;
        issue_valid = 1; issue_is_load = 1; issue_rd = 8;
        #2;
        n_checks++;
        if ({flush_id, bubble_ex, stall_id, stall_if} !== 4'b1100) begin
            n_errors++;
            $display("FAIL br_over_lu: flush_id=%b bubble_ex=%b stall_id=%b stall_if=%b expected 1 1 0 0",
                     flush_id, bubble_ex, stall_id, stall_if);
        end
        next_cycle();
        clear_inputs();
        id_rs1 = 4; id_rs1_used = 1; id_rs2 = 8; id_rs2_used = 0;
        #2;
        n_checks++;
        if ({stall_id, flush_id} !== 2'b10) begin
            n_errors++;
            $display("FAIL br_lu_remains: stall_id=%b flush_id=%b expected 1 0", stall_id, flush_id);
        end
        id_rs1_used = 0; id_rs2_used = 1;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL br_blocks_set: stall_id=%b expected 0", stall_id);
        end
        clear_inputs();
        wb_valid = 1; wb_rd = 4;
        next_cycle();
        clear_inputs();
        mem_load_valid = 1; cache_hit = 0; branch_taken = 1;
        #2;
        n_checks++;
        if ({flush_id, stall_mem, bubble_ex} !== 3'b010) begin
            n_errors++;
            $display("FAIL br_during_miss: flush_id=%b stall_mem=%b bubble_ex=%b expected 0 1 0",
                     flush_id, stall_mem, bubble_ex);
        end
        next_cycle();
        mem_load_valid = 0; refill_done = 1;
        #2;
        n_checks++;
        if (flush_id !== 1'b0) begin
            n_errors++;
            $display("FAIL br_held_in_miss: flush_id=%b expected 0", flush_id);
        end
        next_cycle();
        refill_done = 0;
        #2;
        n_checks++;
        if ({flush_id, bubble_ex, stall_mem} !== 3'b110) begin
            n_errors++;
            $display("FAIL br_after_release: flush_id=%b bubble_ex=%b stall_mem=%b expected 1 1 0",
                     flush_id, bubble_ex, stall_mem);
        end
        n_checks++;
        if (miss_count !== 16'd2) begin
            n_errors++;
            $display("FAIL miss_count_2: got %0d expected 2", miss_count);
        end
        clear_inputs();
    endtask

    task automatic test_timeout_and_reset();
        mem_load_valid = 1; cache_hit = 0;
        next_cycle();
        mem_load_valid = 0;
        repeat (63) next_cycle();
        #2;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_early: timeout_err=%b expected 0 in 64th miss cycle", timeout_err);
        end
        next_cycle();
        #2;
        n_checks++;
        if ({timeout_err, stall_mem} !== 2'b11) begin
            n_errors++;
            $display("FAIL tmo_set: timeout_err=%b stall_mem=%b expected 1 1", timeout_err, stall_mem);
        end
        refill_done = 1;
        next_cycle();
        refill_done = 0;
        #2;
        n_checks++;
        if ({timeout_err, stall_mem} !== 2'b10 || miss_count !== 16'd3) begin
            n_errors++;
            $display("FAIL tmo_sticky: timeout_err=%b stall_mem=%b miss_count=%0d expected 1 0 3",
                     timeout_err, stall_mem, miss_count);
        end
        issue_load(5'd10);
        mem_load_valid = 1; cache_hit = 0;
        next_cycle();
        clear_inputs();
        id_rs1 = 10; id_rs1_used = 1;
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if ({stall_if, stall_id, bubble_ex, stall_mem, flush_id, timeout_err} !== 6'b0 || miss_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid_miss: flags=%b miss_count=%0d expected flags=000000 miss_count=0",
                     {stall_if, stall_id, bubble_ex, stall_mem, flush_id, timeout_err}, miss_count);
        end
        #3;
        rst_n = 1;
        refill_done = 1;
        next_cycle();
        refill_done = 0;
        #2;
        n_checks++;
        if ({stall_mem, stall_id} !== 2'b00) begin
            n_errors++;
            $display("FAIL refill_in_idle: stall_mem=%b stall_id=%b expected 0 0", stall_mem, stall_id);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        issue_load(5'd7);
        issue_valid = 1; issue_is_load = 1; issue_rd = 7;
        wb_valid = 1; wb_rd = 7;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second_issue: stall_id=%b expected 0", stall_id);
        end
        next_cycle();
        clear_inputs();
        id_rs1 = 7; id_rs1_used = 1;
        #2;
        n_checks++;
        if ({stall_id, bubble_ex} !== 2'b11) begin
            n_errors++;
            $display("FAIL b2b_busy_kept: stall_id=%b bubble_ex=%b expected 1 1", stall_id, bubble_ex);
        end
        wb_valid = 1; wb_rd = 7;
        next_cycle();
        wb_valid = 0;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_cleared: stall_id=%b expected 0", stall_id);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_and_nonload();
        test_miss();
        test_branch();
        test_timeout_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5, register-index width; the scoreboard tracks 2**REG_W registers.
REQ-002 Parameter MISS_TIMEOUT, default 64, cycles in MISS before timeout_err sets.
REQ-003 Parameter CNT_W, default 16, width of miss_count.
REQ-004 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 issue_valid  input  1  instruction in ID is leaving ID this cycle (unqualified by stall).
REQ-007 issue_is_load  input  1  issuing instruction is a load.
REQ-008 issue_rd  input  REG_W  destination of the issuing instruction.
REQ-009 id_rs1, id_rs2  input  REG_W each  source indices of the instruction in ID.
REQ-010 id_rs1_used, id_rs2_used  input  1 each  source actually read by the instruction.
REQ-011 mem_load_valid  input  1  load occupies MEM this cycle.
REQ-012 cache_hit  input  1  D-cache hit for the MEM load.
REQ-013 refill_done  input  1  miss data returned (one-cycle pulse).
REQ-014 wb_valid, wb_rd  input  1, REG_W  load result forwardable for wb_rd this cycle.
REQ-015 branch_taken  input  1  EX redirect.
REQ-016 stall_if, stall_id  output  1 each  hold PC and IF/ID register.
REQ-017 bubble_ex  output  1  insert NOP into ID/EX.
REQ-018 stall_mem  output  1  freeze EX/MEM and all earlier stages.
REQ-019 flush_id  output  1  squash IF/ID contents.
REQ-020 miss_count  output  CNT_W  saturating count of misses.
REQ-021 timeout_err  output  1  sticky miss-timeout flag.

Function
REQ-022 busy[r] SHALL set on the clock edge where issue_valid && issue_is_load && issue_rd!=0 && !stall_id && !flush_id && !stall_mem.
REQ-023 busy[r] SHALL clear on the edge where wb_valid && wb_rd==r; simultaneous set and clear of the same r SHALL leave it set.
REQ-024 Source s SHALL be hazardous iff its used bit is 1, s!=0, busy[s]=1, and not (wb_valid && wb_rd==s); register 0 SHALL never be hazardous.
REQ-025 load_use = hazard(rs1) || hazard(rs2); combinational, zero latency.
REQ-026 Miss FSM states IDLE, MISS; IDLE->MISS when mem_load_valid && !cache_hit; MISS->IDLE on refill_done; refill_done in IDLE SHALL be ignored.
REQ-027 stall_mem SHALL be 1 in MISS and combinationally in IDLE when mem_load_valid && !cache_hit.
REQ-028 flush_id = branch_taken && !stall_mem; a branch during stall_mem SHALL be held by EX and take effect after release.
REQ-029 stall_if = stall_id = stall_mem || (load_use && !flush_id).
REQ-030 bubble_ex = !stall_mem && (flush_id || load_use); flush SHALL override load-use.
REQ-031 Timeout counter SHALL clear on entry to MISS, increment each MISS cycle, and set timeout_err when it reaches MISS_TIMEOUT-1; the FSM SHALL remain in MISS; timeout_err SHALL hold until reset.
REQ-032 miss_count SHALL increment once per IDLE->MISS transition and saturate at 2**CNT_W-1.
REQ-033 Busy clears from wb_valid SHALL still apply during stall_mem; sets SHALL be blocked.

Reset
REQ-034 On rst_n low, all busy bits SHALL clear, the FSM SHALL enter IDLE, and counters and timeout_err SHALL be 0, asynchronously, including mid-miss.
REQ-035 During reset, stall_if, stall_id, bubble_ex, stall_mem, and flush_id SHALL be 0 when their inputs are 0.

Structure
REQ-036 Package hazard_pkg SHALL hold the miss-state enum, REG_W default, and MISS_TIMEOUT default.
REQ-037 The miss FSM, timeout counter, and miss_count SHALL live in sub-module hazard_miss_fsm; the scoreboard and combinational stall logic SHALL live in the top level.

Verification
REQ-038 Load to x5, then next ID uses rs1=5 with no wb -> stall_id=1, bubble_ex=1 for exactly the cycles until wb_valid with wb_rd=5; same cycle as wb -> no stall.
REQ-039 Load to x0, then use of x0 -> busy is not set, no stall.
REQ-040 Miss: mem_load_valid=1, cache_hit=0, refill_done after 10 cycles -> stall_mem is 1 for 11 cycles and miss_count=1.
REQ-041 branch_taken together with load_use -> flush_id=1, bubble_ex=1, stall_id=0; branch_taken during MISS -> flush_id=0.
REQ-042 No refill_done for 64 cycles -> timeout_err=1 and stays 1 after refill; rst_n low mid-miss -> IDLE, all outputs 0.
REQ-043 Back-to-back loads to x7, with clear of x7 coinciding with the second set -> busy[7] remains 1.
